// File: rtl/sync_debounce_filter.sv
// Input conditioner: synchroniser chain, enable-paced stable-window filter,
// registered level with rise/fall strobes and a saturating rejected-glitch count.
module sync_debounce_filter #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter int   GLITCH_W      = 8,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_raw,
  input  logic                en,
  input  logic                glitch_clr,
  output logic                level,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int                 CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W:0]     STABLE_V   = (CNT_W + 1)'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

  typedef enum logic [0:0] {
    ST_STABLE    = 1'b0,
    ST_CANDIDATE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   synced_s;
  state_t                 state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [CNT_W:0]         cnt_inc_s;
  logic                   level_r, level_s;
  logic                   rise_r, rise_s;
  logic                   fall_r, fall_s;
  logic                   glitch_s;
  logic [GLITCH_W-1:0]    glitch_cnt_r;

  assign synced_s  = sync_r[SYNC_STAGES-1];
  assign cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};

  // Synchroniser shifts every clock, independent of the filter enable
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], a_raw};
    end
  end

  // Filter next-state: a candidate must survive STABLE_CYCLES enabled samples
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    level_s  = level_r;
    rise_s   = 1'b0;
    fall_s   = 1'b0;
    glitch_s = 1'b0;
    if (en) begin
      case (state_r)
        ST_STABLE: begin
          if (synced_s != level_r) begin
            if (STABLE_CYCLES == 1) begin
              level_s = synced_s;
              rise_s  = synced_s;
              fall_s  = ~synced_s;
              cnt_s   = CNT_ZERO;
            end else begin
              state_s = ST_CANDIDATE;
              cnt_s   = CNT_ONE;
            end
          end else begin
            cnt_s = CNT_ZERO;
          end
        end
        ST_CANDIDATE: begin
          if (synced_s == level_r) begin
            state_s  = ST_STABLE;
            cnt_s    = CNT_ZERO;
            glitch_s = 1'b1;
          end else if (cnt_inc_s < STABLE_V) begin
            cnt_s = cnt_inc_s[CNT_W-1:0];
          end else begin
            state_s = ST_STABLE;
            cnt_s   = CNT_ZERO;
            level_s = synced_s;
            rise_s  = synced_s;
            fall_s  = ~synced_s;
          end
        end
        default: begin
          state_s = ST_STABLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Filter state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_STABLE;
      cnt_r   <= CNT_ZERO;
      level_r <= RESET_LEVEL;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      level_r <= level_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
    end
  end

  // Rejected-glitch counter; clear wins over a same-edge increment
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt_r <= {GLITCH_W{1'b0}};
    end else if (glitch_clr) begin
      glitch_cnt_r <= {GLITCH_W{1'b0}};
    end else if (glitch_s && (glitch_cnt_r != GLITCH_MAX)) begin
      glitch_cnt_r <= glitch_cnt_r + GLITCH_W'(1);
    end else begin
      glitch_cnt_r <= glitch_cnt_r;
    end
  end

  assign level      = level_r;
  assign rise       = rise_r;
  assign fall       = fall_r;
  assign glitch_cnt = glitch_cnt_r;

endmodule
